// File: rtl/latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : latch_write_sequencer
// Purpose  : Lets N_REQ requesters share one level-sensitive D latch. A
//            round-robin arbiter picks one requester and samples its data
//            once. The block then drives the latch in a fixed order: D is
//            set up for one cycle, the gate is held open for HOLD_CYC cycles,
//            and D is held for one more cycle after the gate closes. The
//            owner receives a single-cycle ack in that last cycle.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous reset, active low
//            req       - per-requester write request (level, held until ack)
//            req_data  - requester i data in bits [i*DATA_W +: DATA_W]
//            ack       - one-hot completion pulse to the owner
//            busy      - high whenever the sequencer is not idle
//            owner     - index of the current or most recent owner
//            gate      - latch enable
//            gate_d    - latch D input
// Revision : 1.0 - initial release
// ============================================================================
module latch_write_sequencer #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      gate,
  output logic [DATA_W-1:0]         gate_d
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;
  localparam logic [1:0] ST_CLOSE = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] pick_next;

  // Round-robin search: the first active request at or after rr_ptr wins.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Pointer moves just past the winner so the winner becomes lowest priority.
  assign pick_next = (pick == IDX_LAST) ? '0 : pick + IW'(1);

  // All outputs are registers; each state transition updates them so that
  // gate and gate_d are never changed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      owner  <= '0;
      gate   <= 1'b0;
      gate_d <= '0;
      ack    <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner  <= pick;
            gate_d <= req_data[pick*DATA_W +: DATA_W];
            rr_ptr <= pick_next;
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          gate  <= 1'b1;
          cnt   <= '0;
          state <= ST_OPEN;
        end
        ST_OPEN: begin
          if (cnt == CNT_LAST) begin
            gate  <= 1'b0;
            ack   <= N_REQ'(1) << owner;
            state <= ST_CLOSE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_CLOSE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          gate  <= 1'b0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_write_sequencer
// Purpose  : Directed self-checking bench for latch_write_sequencer. One
//            instance uses HOLD_CYC=2 and a second instance uses HOLD_CYC=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // HOLD_CYC = 2 instance
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  owner;
  logic        gate;
  logic [7:0]  gate_d;

  // HOLD_CYC = 1 instance
  logic [3:0]  h1_req;
  logic [31:0] h1_req_data;
  logic [3:0]  h1_ack;
  logic        h1_busy;
  logic [1:0]  h1_owner;
  logic        h1_gate;
  logic [7:0]  h1_gate_d;

  int n_tests = 0;
  int n_fail  = 0;

  latch_write_sequencer #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .busy(busy), .owner(owner), .gate(gate), .gate_d(gate_d)
  );

  latch_write_sequencer #(.N_REQ(4), .DATA_W(8), .HOLD_CYC(1)) dut_h1 (
    .clk(clk), .rst_n(rst_n), .req(h1_req), .req_data(h1_req_data),
    .ack(h1_ack), .busy(h1_busy), .owner(h1_owner), .gate(h1_gate), .gate_d(h1_gate_d)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req    = '0;
    h1_req = '0;
    rst_n  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    req = '0; h1_req = '0; req_data = '0; h1_req_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_tests++; if (gate !== 1'b0)   begin n_fail++; $display("FAIL reset_gate got=%b exp=0", gate); end
    n_tests++; if (gate_d !== 8'h00) begin n_fail++; $display("FAIL reset_gate_d got=%h exp=00", gate_d); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (owner !== 2'd0)  begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    // start a transaction for requester 1 and abort it during OPEN
    req_data[15:8] = 8'h11;
    req = 4'b0010;
    tick();  // SETUP
    tick();  // OPEN
    n_tests++; if (gate !== 1'b1) begin n_fail++; $display("FAIL reset_pre_open got=%b exp=1", gate); end
    n_tests++; if (owner !== 2'd1) begin n_fail++; $display("FAIL reset_pre_owner got=%0d exp=1", owner); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (gate !== 1'b0)   begin n_fail++; $display("FAIL reset_async_gate got=%b exp=0", gate); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_async_ack got=%b exp=0000", ack); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    n_tests++; if (owner !== 2'd0)  begin n_fail++; $display("FAIL reset_async_owner got=%0d exp=0", owner); end
    req = '0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (busy !== 1'b0 || gate !== 1'b0 || ack !== 4'b0000) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d busy=%b gate=%b ack=%b exp busy=0 gate=0 ack=0000", i, busy, gate, ack);
      end
    end
  endtask

  task automatic test_single_write;
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    tick();  // t+1 SETUP
    n_tests++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    n_tests++; if (gate !== 1'b0)    begin n_fail++; $display("FAIL single_setup_gate got=%b exp=0", gate); end
    n_tests++; if (gate_d !== 8'hA5) begin n_fail++; $display("FAIL single_gate_d got=%h exp=a5", gate_d); end
    n_tests++; if (owner !== 2'd2)   begin n_fail++; $display("FAIL single_owner got=%0d exp=2", owner); end
    tick();  // t+2
    n_tests++; if (gate !== 1'b1) begin n_fail++; $display("FAIL single_open0 got=%b exp=1", gate); end
    tick();  // t+3
    n_tests++; if (gate !== 1'b1)   begin n_fail++; $display("FAIL single_open1 got=%b exp=1", gate); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_early_ack got=%b exp=0000", ack); end
    tick();  // t+4 CLOSE
    n_tests++; if (gate !== 1'b0)    begin n_fail++; $display("FAIL single_close_gate got=%b exp=0", gate); end
    n_tests++; if (ack !== 4'b0100)  begin n_fail++; $display("FAIL single_ack got=%b exp=0100", ack); end
    n_tests++; if (gate_d !== 8'hA5) begin n_fail++; $display("FAIL single_hold_d got=%h exp=a5", gate_d); end
    req = 4'b0000;
    tick();  // t+5 IDLE
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_clear got=%b exp=0000", ack); end
  endtask

  task automatic test_simultaneous;
    int ng;
    int gcyc [4];
    int gown [4];
    logic prev_busy;
    apply_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    ng = 0;
    prev_busy = busy;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy && !prev_busy && ng < 4) begin
        gcyc[ng] = c;
        gown[ng] = int'(owner);
        ng++;
      end
      n_tests++; if ((gate && ack !== 4'b0000) || !$onehot0(ack)) begin
        n_fail++; $display("FAIL simul_ack_rule cyc=%0d gate=%b ack=%b exp no ack during gate, onehot0", c, gate, ack);
      end
      if (ack !== 4'b0000) req = req & ~ack;
      prev_busy = busy;
    end
    n_tests++; if (ng !== 4) begin n_fail++; $display("FAIL simul_grants got=%0d exp=4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_tests++; if (gown[i] !== i) begin n_fail++; $display("FAIL simul_order idx=%0d got=%0d exp=%0d", i, gown[i], i); end
      if (i > 0) begin
        n_tests++; if (gcyc[i] - gcyc[i-1] !== 5) begin
          n_fail++; $display("FAIL simul_spacing idx=%0d got=%0d exp=5", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_fairness;
    int ng;
    int pend_cnt;
    logic [3:0] pend_mask;
    logic prev_busy;
    apply_reset();
    req_data = 32'hD3D3_0000 | 32'h0000_00C0;
    req = 4'b1001;
    ng = 0;
    pend_cnt = 0;
    pend_mask = '0;
    prev_busy = busy;
    for (int c = 0; c < 150 && ng < 20; c++) begin
      tick();
      // re-raise two cycles after the ack cycle, so req stays low in the IDLE cycle
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) req = req | pend_mask;
      end
      if (busy && !prev_busy) begin
        n_tests++; if (owner !== ((ng % 2 == 0) ? 2'd0 : 2'd3)) begin
          n_fail++; $display("FAIL fair_owner grant=%0d got=%0d exp=%0d", ng, owner, (ng % 2 == 0) ? 0 : 3);
        end
        ng++;
      end
      if (ack !== 4'b0000) begin
        req = req & ~ack;
        pend_mask = ack;
        pend_cnt = 2;
      end
      prev_busy = busy;
    end
    n_tests++; if (ng !== 20) begin n_fail++; $display("FAIL fair_grants got=%0d exp=20", ng); end
    req = '0;
    repeat (6) tick();
  endtask

  task automatic test_mid_change;
    int ack_cnt;
    int bad_ack;
    req_data = 32'h0000_3C00;
    req = 4'b0010;
    tick();  // SETUP
    n_tests++; if (gate_d !== 8'h3C) begin n_fail++; $display("FAIL mid_sample got=%h exp=3c", gate_d); end
    tick();  // OPEN
    req_data[15:8] = 8'hFF;
    req = 4'b0000;
    ack_cnt = 0;
    bad_ack = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_tests++; if (gate_d !== 8'h3C) begin n_fail++; $display("FAIL mid_hold cyc=%0d got=%h exp=3c", c, gate_d); end
      if (ack === 4'b0010) ack_cnt++;
      else if (ack !== 4'b0000) bad_ack++;
    end
    n_tests++; if (ack_cnt !== 1) begin n_fail++; $display("FAIL mid_ack_count got=%0d exp=1", ack_cnt); end
    n_tests++; if (bad_ack !== 0) begin n_fail++; $display("FAIL mid_bad_ack got=%0d exp=0", bad_ack); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_hold1;
    int gate_cnt, gate_at, ack_cnt, ack_at;
    logic prev_gate;
    logic [7:0] prev_d;
    gate_cnt = 0; gate_at = -1; ack_cnt = 0; ack_at = -1;
    prev_gate = h1_gate;
    prev_d = h1_gate_d;
    h1_req_data = 32'h0000_005A;
    h1_req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (h1_gate === 1'b1) begin gate_cnt++; gate_at = c; end
      if (h1_ack === 4'b0001) begin ack_cnt++; ack_at = c; h1_req = 4'b0000; end
      n_tests++; if ((h1_gate !== prev_gate) && (h1_gate_d !== prev_d)) begin
        n_fail++; $display("FAIL h1_same_cycle cyc=%0d gate %b->%b d %h->%h exp not both", c, prev_gate, h1_gate, prev_d, h1_gate_d);
      end
      prev_gate = h1_gate;
      prev_d = h1_gate_d;
    end
    n_tests++; if (gate_cnt !== 1) begin n_fail++; $display("FAIL h1_gate_cycles got=%0d exp=1", gate_cnt); end
    n_tests++; if (gate_at !== 2)  begin n_fail++; $display("FAIL h1_gate_at got=%0d exp=2", gate_at); end
    n_tests++; if (ack_cnt !== 1)  begin n_fail++; $display("FAIL h1_ack_count got=%0d exp=1", ack_cnt); end
    n_tests++; if (ack_at !== 3)   begin n_fail++; $display("FAIL h1_ack_at got=%0d exp=3", ack_at); end
    n_tests++; if (h1_gate_d !== 8'h5A) begin n_fail++; $display("FAIL h1_gate_d got=%h exp=5a", h1_gate_d); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_fairness();
    test_mid_change();
    test_hold1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
